// File: rtl/imm_gen_pkg.sv
// Shared opcode, funct3 and format definitions for the immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    // Shift-immediate forms carry a shift amount instead of a signed immediate.
    function automatic logic is_shift_imm(input logic [31:0] instr);
        return ((instr[6:0] == OPC_OPIMM) || (instr[6:0] == OPC_OPIMM32)) &&
               ((instr[14:12] == F3_SLL) || (instr[14:12] == F3_SRX));
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I/RV64I format classifier and immediate extractor.
// Optional macro IMM_ILLEGAL_EN adds the illegal_o flag.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output fmt_e            fmt_o,
    output logic [XLEN-1:0] imm_o
`ifdef IMM_ILLEGAL_EN
    ,
    output logic            illegal_o
`endif
);

    logic [6:0]  opc;
    logic [31:0] imm32;

    assign opc = instr_i[6:0];

    // Classify by opcode and assemble the low 32 immediate bits.
    always_comb begin
        fmt_o = FMT_NONE;
        imm32 = '0;
        if (instr_i[1:0] == 2'b11) begin
            case (opc)
                OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
                    fmt_o = FMT_I;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                OPC_OPIMM, OPC_OPIMM32: begin
                    fmt_o = FMT_I;
                    if (is_shift_imm(instr_i)) begin
                        if ((XLEN == 64) && (opc == OPC_OPIMM)) begin
                            imm32 = {26'b0, instr_i[25:20]};
                        end else begin
                            imm32 = {27'b0, instr_i[24:20]};
                        end
                    end else begin
                        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                    end
                end
                OPC_STORE: begin
                    fmt_o = FMT_S;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                end
                OPC_BRANCH: begin
                    fmt_o = FMT_B;
                    imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt_o = FMT_U;
                    imm32 = {instr_i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    fmt_o = FMT_J;
                    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
                end
                OPC_OP, OPC_OP32: begin
                    fmt_o = FMT_R;
                end
                default: begin
                    fmt_o = FMT_NONE;
                end
            endcase
        end
    end

    // Widen to XLEN: bit 31 is the sign for signed forms and already 0 for
    // zero-extended shift amounts, so one replication covers both.
    always_comb begin
        imm_o       = {XLEN{imm32[31]}};
        imm_o[31:0] = imm32;
    end

`ifdef IMM_ILLEGAL_EN
    // Flag unknown encodings and RV64-only encodings on a 32-bit datapath.
    always_comb begin
        illegal_o = (fmt_o == FMT_NONE);
        if (XLEN == 32) begin
            if ((opc == OPC_OPIMM32) || (opc == OPC_OP32)) begin
                illegal_o = 1'b1;
            end
            if (is_shift_imm(instr_i) && instr_i[25]) begin
                illegal_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode at push, DEPTH-entry in-order FIFO,
// valid/ready on both sides, synchronous flush.
// Optional macro IMM_ILLEGAL_EN adds the per-entry out_illegal output.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_instr
`ifdef IMM_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
`ifdef IMM_ILLEGAL_EN
    logic            dec_illegal;
`endif

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr_i  (in_instr),
        .fmt_o    (dec_fmt),
        .imm_o    (dec_imm)
`ifdef IMM_ILLEGAL_EN
        ,
        .illegal_o(dec_illegal)
`endif
    );

    logic            rdy_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic            push, pop;

    logic [XLEN-1:0] imm_q   [DEPTH];
    logic [2:0]      fmt_q   [DEPTH];
    logic [31:0]     instr_q [DEPTH];
`ifdef IMM_ILLEGAL_EN
    logic            ill_q   [DEPTH];
`endif

    assign out_valid = (cnt_q != '0);
    assign in_ready  = rdy_q && (cnt_q < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer and occupancy update; flush clears everything and drops a push.
    always_comb begin
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (flush) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control state; rdy_q holds in_ready low until the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    // Entry storage; contents are only observable while counted as valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            imm_q[wr_q]   <= dec_imm;
            fmt_q[wr_q]   <= dec_fmt;
            instr_q[wr_q] <= in_instr;
`ifdef IMM_ILLEGAL_EN
            ill_q[wr_q]   <= dec_illegal;
`endif
        end
    end

    // Head outputs read as zero when the FIFO is empty.
    always_comb begin
        out_imm   = '0;
        out_fmt   = '0;
        out_instr = '0;
`ifdef IMM_ILLEGAL_EN
        out_illegal = 1'b0;
`endif
        if (out_valid) begin
            out_imm   = imm_q[rd_q];
            out_fmt   = fmt_q[rd_q];
            out_instr = instr_q[rd_q];
`ifdef IMM_ILLEGAL_EN
            out_illegal = ill_q[rd_q];
`endif
        end
    end

endmodule
